fp_sub_seq: RTL

Multi-cycle IEEE-754 single-precision subtractor that computes out = para1 - para2. It is the inverse operation to the combinational AddOp adder in the FPU datapath. It sits beside AddOp in the ALU and uses the same operand and result encoding, plus a start/done handshake. Alignment and normalisation each shift one bit per cycle, so area stays small at the cost of variable latency.

---
 rtl/fp_sub_seq.sv | 183 ++++++++++++++++++
 1 files changed

// File: rtl/fp_sub_seq.sv
// rtl/fp_sub_seq.sv - multi-cycle IEEE-754 single subtractor (optional FP_SUB_ADD_MODE_EN add/sub select)
module fp_sub_seq #(
    parameter int MAX_ALIGN = 25
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [31:0] para1,
    input  logic [31:0] para2,
`ifdef FP_SUB_ADD_MODE_EN
    input  logic        op_sel,
`endif
    output logic        busy,
    output logic        done,
    output logic [31:0] out,
    output logic        under_overflow
);

    typedef enum logic [2:0] {
        S_IDLE, S_UNPACK, S_ALIGN, S_ADD, S_NORM, S_PACK
    } state_t;

    localparam logic [8:0] MAX_ALIGN_W = 9'(MAX_ALIGN);

    state_t state, state_nxt;

    logic [31:0]       op_a, op_b;
    logic              sign_a, sign_b;
    logic [7:0]        exp_a;
    logic [23:0]       mant_a, mant_b;
    logic [7:0]        d;
    logic [24:0]       sum;
    logic signed [9:0] res_exp;
    logic              is_zero;

    logic [7:0]  ea, eb, big_exp, small_exp, diff;
    logic [23:0] ma, mb;
    logic        a_big, any_inf, zero_small, skip_align;
    logic [24:0] sum_c;
    logic        para2_sign;

    // Sign of the latched subtrahend: inverted for subtraction, kept for addition
    always_comb begin
`ifdef FP_SUB_ADD_MODE_EN
        para2_sign = op_sel ? para2[31] : ~para2[31];
`else
        para2_sign = ~para2[31];
`endif
    end

    // Unpack both operands, flush denormals, and order them by magnitude
    always_comb begin
        ea         = op_a[30:23];
        eb         = op_b[30:23];
        ma         = (ea == 8'h00) ? 24'h0 : {1'b1, op_a[22:0]};
        mb         = (eb == 8'h00) ? 24'h0 : {1'b1, op_b[22:0]};
        a_big      = (ea > eb) || ((ea == eb) && (ma >= mb));
        big_exp    = a_big ? ea : eb;
        small_exp  = a_big ? eb : ea;
        diff       = big_exp - small_exp;
        any_inf    = (ea == 8'hFF) || (eb == 8'hFF);
        zero_small = ({1'b0, diff} >= MAX_ALIGN_W);
        skip_align = (diff == 8'h00) || zero_small;
    end

    // Magnitude add or subtract of the aligned mantissas; A >= B so never negative
    always_comb begin
        sum_c = 25'h0;
        if (sign_a ^ sign_b)
            sum_c = {1'b0, mant_a} - {1'b0, mant_b};
        else
            sum_c = {1'b0, mant_a} + {1'b0, mant_b};
    end

    // State register
    always_ff @(posedge clk) begin
        if (!rst)
            state <= S_IDLE;
        else
            state <= state_nxt;
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:   if (start) state_nxt = S_UNPACK;
            S_UNPACK: begin
                if (any_inf)         state_nxt = S_PACK;
                else if (skip_align) state_nxt = S_ADD;
                else                 state_nxt = S_ALIGN;
            end
            S_ALIGN:  if (d == 8'd1) state_nxt = S_ADD;
            S_ADD: begin
                if (sum_c == 25'h0)              state_nxt = S_PACK;
                else if (sum_c[24] || !sum_c[23]) state_nxt = S_NORM;
                else                             state_nxt = S_PACK;
            end
            S_NORM:   if (sum[24] || sum[22]) state_nxt = S_PACK;
            S_PACK:   state_nxt = S_IDLE;
            default:  state_nxt = S_IDLE;
        endcase
    end

    // Output logic
    always_comb begin
        busy = (state != S_IDLE);
    end

    // Datapath registers and result/done registers
    always_ff @(posedge clk) begin
        if (!rst) begin
            op_a           <= 32'h0;
            op_b           <= 32'h0;
            sign_a         <= 1'b0;
            sign_b         <= 1'b0;
            exp_a          <= 8'h0;
            mant_a         <= 24'h0;
            mant_b         <= 24'h0;
            d              <= 8'h0;
            sum            <= 25'h0;
            res_exp        <= 10'sd0;
            is_zero        <= 1'b0;
            done           <= 1'b0;
            out            <= 32'h0;
            under_overflow <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: if (start) begin
                    op_a <= para1;
                    op_b <= {para2_sign, para2[30:0]};
                end
                S_UNPACK: begin
                    sign_a  <= a_big ? op_a[31] : op_b[31];
                    sign_b  <= a_big ? op_b[31] : op_a[31];
                    exp_a   <= big_exp;
                    mant_a  <= a_big ? ma : mb;
                    mant_b  <= zero_small ? 24'h0 : (a_big ? mb : ma);
                    d       <= zero_small ? 8'h0 : diff;
                    is_zero <= 1'b0;
                    res_exp <= any_inf ? 10'sd255 : 10'sd0;
                end
                S_ALIGN: begin
                    mant_b <= mant_b >> 1;
                    d      <= d - 8'd1;
                end
                S_ADD: begin
                    sum     <= sum_c;
                    res_exp <= signed'({2'b00, exp_a});
                    is_zero <= (sum_c == 25'h0);
                end
                S_NORM: begin
                    if (sum[24]) begin
                        sum     <= sum >> 1;
                        res_exp <= res_exp + 10'sd1;
                    end else begin
                        sum     <= sum << 1;
                        res_exp <= res_exp - 10'sd1;
                    end
                end
                S_PACK: begin
                    done <= 1'b1;
                    if (is_zero) begin
                        out            <= 32'h0;
                        under_overflow <= 1'b0;
                    end else if (res_exp >= 10'sd255) begin
                        out            <= {sign_a, 8'hFF, 23'h0};
                        under_overflow <= 1'b1;
                    end else if (res_exp <= 10'sd0) begin
                        out            <= {sign_a, 31'h0};
                        under_overflow <= 1'b1;
                    end else begin
                        out            <= {sign_a, res_exp[7:0], sum[22:0]};
                        under_overflow <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
